// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch/prefetch unit.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int FETCH_XLEN  = 32;
  localparam int FETCH_TAG_W = 4;
  localparam int PC_STEP     = 4;

  // Queue entry layout for the default configuration (XLEN=32, TAG_W=4).
  // The top re-declares the same layout with its own parameter widths.
  typedef struct packed {
    logic [FETCH_XLEN-1:0]  instr;
    logic [FETCH_XLEN-1:0]  pc;
    logic [FETCH_TAG_W-1:0] tag;
  } fetch_entry_t;

  // Word-align a target address. 64 bits wide so any XLEN up to 64 can use it.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'd3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers, synchronous flush and reset.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
// Ports: clk, reset (sync, active-high), flush (sync, beats push/pop), push/push_data,
//        pop, head, count, full, empty.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  T            mem_q [DEPTH];
  logic [AW:0] wr_q;
  logic [AW:0] rd_q;
  logic        do_push;
  logic        do_pop;

  // Extra MSB on each pointer distinguishes full from empty.
  assign count = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (count == DEPTH_C);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      // Clearing storage makes the head fields read as zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      // Discard everything; storage is left untouched so head holds a stale value.
      rd_q <= wr_q;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= push_data;
        wr_q                <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

  assign head = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/fetch_prefetch.sv
// PC generator plus DEPTH-entry prefetch queue between instruction memory and decode.
// Latency: out_valid 2 cycles after i_req into an empty queue; 1 instr/cycle sustained.
// Backpressure: out_ready low fills the queue; issue stops when queued+in-flight reach DEPTH.
// Ports: clk, reset (sync, active-high), redirect/redirect_pc (flush + new PC),
//        i_req/i_address/i_rdata (memory, 1-cycle read), out_valid/out_ready/out_instr/
//        out_pc/out_tag (decode handshake).
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] START_ADDR = '0,
  parameter int              DEPTH      = 4,
  parameter int              TAG_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             i_req,
  output logic [XLEN-1:0]  i_address,
  input  logic [XLEN-1:0]  i_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  typedef struct packed {
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  pc;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             inflight_q;
  logic [XLEN-1:0]  req_pc_q;
  logic [TAG_W-1:0] req_tag_q;

  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  entry_t           fifo_head;
  entry_t           push_entry;
  logic [CW:0]      credits_used;
  logic [XLEN-1:0]  target_pc;

  // Every in-flight request owns a queue slot, so a response can always be pushed.
  assign credits_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign i_req        = !reset && !redirect && (credits_used < DEPTH_C);
  assign i_address    = pc_q;

  assign target_pc = XLEN'(align_pc(64'(redirect_pc)));

  always_comb begin
    pc_d  = pc_q;
    tag_d = tag_q;
    if (redirect) begin
      pc_d  = target_pc;
      tag_d = tag_q + 1'b1;
    end else if (i_req) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= START_ADDR;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
      req_tag_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= i_req;
      req_pc_q   <= pc_q;
      req_tag_q  <= tag_q;
    end
  end

  // A response fetched under an older tag belongs to a redirected-away path.
  // A response arriving in a redirect cycle is also killed by the flush below.
  assign fifo_push = inflight_q && (req_tag_q == tag_q) && !redirect;
  assign fifo_pop  = out_valid && out_ready;

  always_comb begin
    push_entry       = '0;
    push_entry.instr = i_rdata;
    push_entry.pc    = req_pc_q;
    push_entry.tag   = req_tag_q;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_instr = fifo_head.instr;
  assign out_pc    = fifo_head.pc;
  assign out_tag   = fifo_head.tag;

  // The credit check must make an unpaired push into a full queue impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_fetch_prefetch.sv
module tb_fetch_prefetch;
  import fetch_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        i_req;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [3:0]  out_tag;

  int checks = 0;
  int errors = 0;

  fetch_entry_t exp_q[$];

  fetch_prefetch #(
    .XLEN       (32),
    .START_ADDR (32'h0000_0000),
    .DEPTH      (4),
    .TAG_W      (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .i_req       (i_req),
    .i_address   (i_address),
    .i_rdata     (i_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_tag     (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: data for the address presented last cycle.
  logic [31:0] mem_addr_q;
  always @(posedge clk) mem_addr_q <= i_address;
  assign i_rdata = mem_addr_q ^ KEY;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [3:0] tag);
    fetch_entry_t e;
    e.instr = pc ^ KEY;
    e.pc    = pc;
    e.tag   = tag;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every decode handshake must match the next expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got pc=%h tag=%h, expected no handshake", out_pc, out_tag);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        if (out_pc !== e.pc || out_tag !== e.tag || out_instr !== e.instr) begin
          errors++;
          $display("FAIL pop: got pc=%h tag=%h instr=%h expected pc=%h tag=%h instr=%h",
                   out_pc, out_tag, out_instr, e.pc, e.tag, e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_i_req", 32'(i_req), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_out_instr", out_instr, 0);

    // Test 1: streaming with decode always ready.
    for (int i = 0; i < 6; i++) push_exp(32'(i) * 4, 4'd0);
    cyc(); reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc();
      @(negedge clk);
      if (c < 5) begin
        chk("t1_i_req", 32'(i_req), 1);
        chk("t1_i_address", i_address, 32'(c) * 4);
      end
      if (c < 2) chk("t1_latency_out_valid", 32'(out_valid), 0);
    end
    cyc(); reset = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("t1_drained", 32'(exp_q.size()), 0);

    // Test 2: decode stalled, queue fills to DEPTH, then drains in order.
    cyc();
    for (int i = 0; i < 4; i++) push_exp(32'(i) * 4, 4'd0);
    cyc(); reset = 1'b0;                      // cycle 0
    repeat (9) cyc();                         // cycle 9
    @(negedge clk);
    chk("t2_full_i_req", 32'(i_req), 0);
    chk("t2_full_out_valid", 32'(out_valid), 1);
    chk("t2_full_head_pc", out_pc, 0);
    chk("t2_full_i_address", i_address, 32'h10);
    cyc(); out_ready = 1'b1;                  // cycle 10
    repeat (3) cyc();                         // cycles 11..13
    cyc(); out_ready = 1'b0;                  // cycle 14

    // Test 3: redirect with 3 queued (pc 0x10..0x18) and 0x1c in flight.
    cyc(); redirect = 1'b1; redirect_pc = 32'h100;   // cycle 15
    for (int i = 0; i < 4; i++) push_exp(32'h100 + 32'(i) * 4, 4'd1);
    @(negedge clk);
    chk("t2_drained", 32'(exp_q.size()), 4);
    chk("t3_redirect_no_req", 32'(i_req), 0);
    chk("t3_pre_head_pc", out_pc, 32'h10);
    cyc(); redirect = 1'b0; out_ready = 1'b1;        // cycle 16
    @(negedge clk);
    chk("t3_i_req", 32'(i_req), 1);
    chk("t3_i_address", i_address, 32'h100);
    chk("t3_flushed", 32'(out_valid), 0);
    cyc();                                           // cycle 17
    @(negedge clk);
    chk("t3_squashed", 32'(out_valid), 0);
    cyc();                                           // cycle 18
    @(negedge clk);
    chk("t3_first_valid", 32'(out_valid), 1);
    chk("t3_first_tag", 32'(out_tag), 1);
    repeat (2) cyc();                                // cycles 19,20

    // Test 4: unaligned target, with a pop completing in the redirect cycle.
    cyc(); redirect = 1'b1; redirect_pc = 32'h203;   // cycle 21
    push_exp(32'h200, 4'd2);
    push_exp(32'h204, 4'd2);
    cyc(); redirect = 1'b0;                          // cycle 22
    @(negedge clk);
    chk("t4_align_i_address", i_address, 32'h200);
    repeat (2) cyc();                                // cycles 23,24

    // 14 back-to-back redirects take the tag from 2 through 15 to 0.
    push_exp(32'h300, 4'd0);
    push_exp(32'h304, 4'd0);
    for (int k = 0; k < 14; k++) begin               // cycles 25..38
      cyc();
      redirect = 1'b1;
      redirect_pc = (k == 13) ? 32'h300 : 32'h1000 + 32'(k) * 16;
      if (k == 5) begin
        @(negedge clk);
        chk("t4_burst_no_req", 32'(i_req), 0);
        chk("t4_burst_no_valid", 32'(out_valid), 0);
      end
    end
    cyc(); redirect = 1'b0;                          // cycle 39
    @(negedge clk);
    chk("t4_wrap_i_address", i_address, 32'h300);
    repeat (2) cyc();                                // cycles 40,41
    @(negedge clk);
    chk("t4_wrap_tag", 32'(out_tag), 0);

    // Test 5: redirects on two consecutive cycles, last target wins.
    cyc(); redirect = 1'b1; redirect_pc = 32'h40;    // cycle 42
    for (int i = 0; i < 3; i++) push_exp(32'h80 + 32'(i) * 4, 4'd2);
    cyc(); redirect_pc = 32'h80;                     // cycle 43
    cyc(); redirect = 1'b0;                          // cycle 44
    @(negedge clk);
    chk("t5_i_address", i_address, 32'h80);
    repeat (4) cyc();                                // cycles 45..48

    // Test 6: reset while queue holds 3 and one response is in flight.
    cyc(); out_ready = 1'b0;                         // cycle 49
    cyc();                                           // cycle 50
    cyc(); reset = 1'b1;                             // cycle 51
    push_exp(32'h0, 4'd0);
    push_exp(32'h4, 4'd0);
    @(negedge clk);
    chk("t6_reset_i_req", 32'(i_req), 0);
    cyc(); reset = 1'b0; out_ready = 1'b1;           // cycle 52
    @(negedge clk);
    chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_i_address", i_address, 32'h0);
    chk("t6_i_req", 32'(i_req), 1);
    chk("t6_out_tag", 32'(out_tag), 0);
    chk("t6_out_pc", out_pc, 0);
    repeat (3) cyc();                                // cycles 53..55
    cyc(); out_ready = 1'b0;                         // cycle 56
    repeat (3) cyc();
    @(negedge clk);
    chk("final_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
